sseg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the SoC's 8-digit seven-segment display (`r_sg`/`r_an`). It owns the display: a bus-side register file holds eight hex digits, a per-digit enable mask and decimal points. A prescaled scheduler then gives each digit one time slot per frame, with anode blanking between slots. It sits in the SoC peripheral space beside GPIO/UART/SPI and drives the top-level display pins directly.

---
 rtl/sseg_scan_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_sseg_scan_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sseg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sseg_scan_ctrl
//  Purpose  : Time-multiplexed scan controller for an 8-digit seven-segment
//             display. A bus-side register file holds eight hex digits, a
//             digit-enable mask and decimal-point mask. A prescaled scheduler
//             gives each digit one slot per frame, with all anodes blanked
//             for the first BLANK_CYC cycles of every slot.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    SCAN_DIV   clock cycles per digit slot (4 .. 2**20)
//    BLANK_CYC  blanked cycles at the start of each slot (< SCAN_DIV)
//  Ports
//    clk        in   1   system clock
//    rst_n      in   1   asynchronous assert, active-low reset
//    wr_en_i    in   1   register write strobe
//    rd_en_i    in   1   register read strobe
//    addr_i     in   1   0 = DIGITS, 1 = CTRL
//    wr_data_i  in  32   write data
//    rd_data_o  out 32   registered read data, held until the next read
//    r_sg       out  8   segments, active-low (bit0..6 = a..g, bit7 = dp)
//    r_an       out  8   anodes, active-low (bit n = digit n)
//    frame_o    out  1   one-cycle pulse when slot 7 ends
//  Build option
//    SSEG_DIM_EN  when defined, adds a 16-step duty (brightness) control in
//                 CTRL[19:16]; otherwise those bits read 0 and ignore writes.
// ============================================================================
module sseg_scan_ctrl #(
  parameter int unsigned SCAN_DIV  = 100000,
  parameter int unsigned BLANK_CYC = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en_i,
  input  logic        rd_en_i,
  input  logic        addr_i,
  input  logic [31:0] wr_data_i,
  output logic [31:0] rd_data_o,
  output logic [7:0]  r_sg,
  output logic [7:0]  r_an,
  output logic        frame_o
);

  localparam int unsigned     C_PW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [C_PW-1:0] C_PCNT_TC = C_PW'(SCAN_DIV - 1);
  localparam logic [C_PW-1:0] C_BLANK   = C_PW'(BLANK_CYC);
  localparam logic [C_PW-1:0] C_ONE     = C_PW'(1);

  // --------------------------------------------------------------------------
  // Register file: staging (bus side) and shadow (display side)
  // --------------------------------------------------------------------------
  logic [31:0] r_stg_digits;
  logic [7:0]  r_stg_mask;
  logic [7:0]  r_stg_dp;
  logic [31:0] r_shd_digits;
  logic [7:0]  r_shd_mask;
  logic [7:0]  r_shd_dp;
  logic [3:0]  w_ctrl_duty;

  logic [C_PW-1:0] r_pcnt;
  logic [2:0]      r_idx;
  logic            w_wrap;

  assign w_wrap = (r_idx == 3'd7) && (r_pcnt == C_PCNT_TC);

`ifdef SSEG_DIM_EN
  logic [3:0] r_stg_duty;
  logic [3:0] r_shd_duty;
  logic [3:0] r_dcnt;
  logic       w_unused_wdata;

  assign w_ctrl_duty    = r_stg_duty;
  assign w_unused_wdata = ^wr_data_i[31:20];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stg_duty <= 4'hF;
      r_shd_duty <= 4'hF;
      r_dcnt     <= 4'h0;
    end else begin
      r_dcnt <= r_dcnt + 4'h1;
      if (wr_en_i && addr_i) begin
        r_stg_duty <= wr_data_i[19:16];
      end
      // Shadow copy is taken before a coincident write lands in staging.
      if (w_wrap) begin
        r_shd_duty <= r_stg_duty;
      end
    end
  end
`else
  logic w_unused_wdata;

  assign w_ctrl_duty    = 4'h0;
  assign w_unused_wdata = ^wr_data_i[31:16];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stg_digits <= 32'h0;
      r_stg_mask   <= 8'h0;
      r_stg_dp     <= 8'h0;
    end else if (wr_en_i) begin
      if (!addr_i) begin
        r_stg_digits <= wr_data_i;
      end else begin
        r_stg_mask <= wr_data_i[7:0];
        r_stg_dp   <= wr_data_i[15:8];
      end
    end
  end

  // Shadow loads only at frame wrap so a multi-write update never tears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shd_digits <= 32'h0;
      r_shd_mask   <= 8'h0;
      r_shd_dp     <= 8'h0;
    end else if (w_wrap) begin
      r_shd_digits <= r_stg_digits;
      r_shd_mask   <= r_stg_mask;
      r_shd_dp     <= r_stg_dp;
    end
  end

  // Reads return staging; a same-cycle write is seen on the next read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_o <= 32'h0;
    end else if (rd_en_i) begin
      if (addr_i) begin
        rd_data_o <= {12'h0, w_ctrl_duty, r_stg_dp, r_stg_mask};
      end else begin
        rd_data_o <= r_stg_digits;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Slot scheduler
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pcnt <= '0;
      r_idx  <= 3'd0;
    end else if (r_pcnt == C_PCNT_TC) begin
      r_pcnt <= '0;
      r_idx  <= r_idx + 3'd1;
    end else begin
      r_pcnt <= r_pcnt + C_ONE;
    end
  end

  // --------------------------------------------------------------------------
  // Output decode
  // --------------------------------------------------------------------------
  function automatic logic [6:0] seg7(input logic [3:0] hex);
    logic [6:0] seg;
    case (hex)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  logic [3:0] w_cur_hex;
  logic       w_blank;
  logic       w_an_on;
  logic [7:0] w_an_nxt;
  logic [7:0] w_sg_nxt;

  assign w_cur_hex = r_shd_digits[{r_idx, 2'b00} +: 4];

  always_comb begin
    w_blank  = (r_pcnt < C_BLANK);
    w_an_on  = r_shd_mask[r_idx] && !w_blank;
`ifdef SSEG_DIM_EN
    w_an_on  = w_an_on && (r_dcnt <= r_shd_duty);
`endif
    w_an_nxt = 8'hFF;
    w_sg_nxt = 8'hFF;
    // Segment lines follow the anode: whenever no digit is lit they are
    // released too, which keeps the display fully dark after reset.
    if (w_an_on) begin
      w_an_nxt = ~(8'h01 << r_idx);
      w_sg_nxt = {~r_shd_dp[r_idx], seg7(w_cur_hex)};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an    <= 8'hFF;
      r_sg    <= 8'hFF;
      frame_o <= 1'b0;
    end else begin
      r_an    <= w_an_nxt;
      r_sg    <= w_sg_nxt;
      frame_o <= w_wrap;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sseg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sseg_scan_ctrl
//  Purpose  : Self-checking bench for sseg_scan_ctrl (SCAN_DIV=8, BLANK_CYC=2).
//             Expected outputs come from a cycle-count reference model: the
//             displayed slot/phase are derived arithmetically from the number
//             of clock edges since reset release.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sseg_scan_ctrl;

  localparam int unsigned SD = 8;
  localparam int unsigned BC = 2;
  localparam int unsigned FR = 8 * SD;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic        addr  = 1'b0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic [7:0]  sg;
  logic [7:0]  an;
  logic        frame;

  sseg_scan_ctrl #(
    .SCAN_DIV  (SD),
    .BLANK_CYC (BC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (wr_en),
    .rd_en_i   (rd_en),
    .addr_i    (addr),
    .wr_data_i (wdata),
    .rd_data_o (rdata),
    .r_sg      (sg),
    .r_an      (an),
    .frame_o   (frame)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

`ifdef SSEG_DIM_EN
  localparam logic [3:0] DUTY_RST = 4'hF;
`else
  localparam logic [3:0] DUTY_RST = 4'h0;
`endif

  // Reference model state
  int unsigned m_n;
  int unsigned m_slot;
  int unsigned m_phase;
  bit          m_lit;
  logic [31:0] m_dig_stg, m_dig_shd;
  logic [7:0]  m_mask_stg, m_mask_shd, m_dp_stg, m_dp_shd;
  logic [3:0]  m_duty_stg, m_duty_shd;
  logic [7:0]  e_sg, e_an;
  logic        e_frame;
  logic [31:0] e_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_n        = 0;
    m_dig_stg  = 32'h0; m_dig_shd  = 32'h0;
    m_mask_stg = 8'h0;  m_mask_shd = 8'h0;
    m_dp_stg   = 8'h0;  m_dp_shd   = 8'h0;
    m_duty_stg = DUTY_RST; m_duty_shd = DUTY_RST;
    e_sg = 8'hFF; e_an = 8'hFF; e_frame = 1'b0; e_rd = 32'h0;
  endtask

  // Predicts outputs after the coming clock edge from the current inputs.
  task automatic model_step();
    if (!rst_n) return;
    m_slot  = (m_n / SD) % 8;
    m_phase = m_n % SD;
    m_lit   = (m_phase >= BC) && m_mask_shd[m_slot];
`ifdef SSEG_DIM_EN
    if ((m_n % 16) > m_duty_shd) m_lit = 1'b0;
`endif
    if (m_lit) begin
      e_an = ~(8'h01 << m_slot);
      e_sg = {~m_dp_shd[m_slot], seg_tab[m_dig_shd[4*m_slot +: 4]]};
    end else begin
      e_an = 8'hFF;
      e_sg = 8'hFF;
    end
    e_frame = ((m_n % FR) == FR - 1);
    if (rd_en) e_rd = addr ? {12'h0, m_duty_stg, m_dp_stg, m_mask_stg} : m_dig_stg;
    if (e_frame) begin
      m_dig_shd = m_dig_stg; m_mask_shd = m_mask_stg;
      m_dp_shd  = m_dp_stg;  m_duty_shd = m_duty_stg;
    end
    if (wr_en) begin
      if (addr) begin
        m_mask_stg = wdata[7:0];
        m_dp_stg   = wdata[15:8];
`ifdef SSEG_DIM_EN
        m_duty_stg = wdata[19:16];
`endif
      end else begin
        m_dig_stg = wdata;
      end
    end
    m_n++;
  endtask

  // Drive inputs at a falling edge, advance one cycle, check everything.
  task automatic tick(input logic we, input logic re, input logic a, input logic [31:0] d);
    wr_en = we; rd_en = re; addr = a; wdata = d;
    model_step();
    @(negedge clk);
    chk("an", {24'h0, an}, {24'h0, e_an});
    chk("sg", {24'h0, sg}, {24'h0, e_sg});
    chk("frame", {31'h0, frame}, {31'h0, e_frame});
    chk("rd", rdata, e_rd);
  endtask

  // Advance until the displayed output belongs to slot s, phase p.
  task automatic go_to(input int unsigned s, input int unsigned p);
    for (int k = 0; k < 2 * FR; k++) begin
      tick(1'b0, 1'b0, 1'b0, 32'h0);
      if ((((m_n - 1) / SD) % 8 == s) && ((m_n - 1) % SD == p)) break;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int exp_on;
    int got_on;

    // ---- reset ------------------------------------------------------------
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_an", {24'h0, an}, 32'hFF);
    chk("rst_sg", {24'h0, sg}, 32'hFF);
    chk("rst_frame", {31'h0, frame}, 32'h0);
    chk("rst_rd", rdata, 32'h0);
    @(negedge clk);
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    rst_n = 1'b1;

    // ---- dark display, frame pulses every 64 cycles -----------------------
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      tick(1'b0, 1'b0, 1'b0, 32'h0);
      if (frame) cnt++;
      if (an !== 8'hFF || sg !== 8'hFF) chk("dark", {16'h0, an, sg}, 32'hFFFF);
    end
    chk("frames200", cnt, 3);

    // ---- basic digits, all enabled ----------------------------------------
    tick(1'b1, 1'b0, 1'b0, 32'h76543210);
    tick(1'b1, 1'b0, 1'b1, 32'h000000FF);
    tick(1'b0, 1'b1, 1'b0, 32'h0);
    chk("rd_digits", rdata, 32'h76543210);
    tick(1'b0, 1'b1, 1'b1, 32'h0);
    chk("rd_ctrl", rdata, {12'h0, DUTY_RST, 16'h00FF});
    go_to(0, 0);
    chk("s0_blank_an", {24'h0, an}, 32'hFF);
    chk("s0_blank_sg", {24'h0, sg}, 32'hFF);
    go_to(0, 2);
    chk("s0_an", {24'h0, an}, 32'hFE);
    chk("s0_sg", {24'h0, sg}, 32'hC0);
    go_to(3, 2);
    chk("s3_an", {24'h0, an}, 32'hF7);
    chk("s3_sg", {24'h0, sg}, 32'hB0);

    // ---- mask 05 with dp on digit 0 ---------------------------------------
    tick(1'b1, 1'b0, 1'b1, 32'h00000105);
    go_to(0, 2);
    chk("m_s0_an", {24'h0, an}, 32'hFE);
    chk("m_s0_sg", {24'h0, sg}, 32'h40);
    go_to(1, 4);
    chk("m_s1_an", {24'h0, an}, 32'hFF);
    go_to(2, 2);
    chk("m_s2_an", {24'h0, an}, 32'hFB);
    chk("m_s2_sg", {24'h0, sg}, 32'hA4);
    go_to(5, 5);
    chk("m_s5_an", {24'h0, an}, 32'hFF);

    // ---- write coincident with frame wrap ---------------------------------
    tick(1'b1, 1'b0, 1'b1, 32'h00000005);
    go_to(0, 0);
    go_to(7, 6);
    tick(1'b1, 1'b0, 1'b0, 32'hFFFFFFFF);
    chk("wrap_frame", {31'h0, frame}, 32'h1);
    tick(1'b0, 1'b1, 1'b0, 32'h0);
    chk("wrap_rd", rdata, 32'hFFFFFFFF);
    go_to(0, 2);
    chk("old_s0_sg", {24'h0, sg}, 32'hC0);
    go_to(2, 2);
    chk("old_s2_sg", {24'h0, sg}, 32'hA4);
    go_to(0, 2);
    chk("new_s0_sg", {24'h0, sg}, 32'h8E);
    go_to(2, 2);
    chk("new_s2_an", {24'h0, an}, 32'hFB);
    chk("new_s2_sg", {24'h0, sg}, 32'h8E);

    // ---- randomized traffic -----------------------------------------------
    for (int i = 0; i < 4 * FR; i++) begin
      tick(($urandom % 4) == 0, ($urandom % 2) == 1, ($urandom % 2) == 1, $urandom);
    end

    // ---- asynchronous reset mid slot 5 ------------------------------------
    go_to(5, 3);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_an", {24'h0, an}, 32'hFF);
    chk("arst_sg", {24'h0, sg}, 32'hFF);
    chk("arst_frame", {31'h0, frame}, 32'h0);
    chk("arst_rd", rdata, 32'h0);
    @(negedge clk);
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    rst_n = 1'b1;
    tick(1'b0, 1'b1, 1'b0, 32'h0);
    chk("arst_rd_dig", rdata, 32'h0);
    tick(1'b0, 1'b1, 1'b1, 32'h0);
    chk("arst_rd_ctrl", rdata, {12'h0, DUTY_RST, 16'h0});
    cnt = 2;
    for (int i = 0; i < 200; i++) begin
      tick(1'b0, 1'b0, 1'b0, 32'h0);
      cnt++;
      if (frame) break;
    end
    chk("restart_frame_at", cnt, 64);

    // ---- duty field ---------------------------------------------------------
`ifdef SSEG_DIM_EN
    tick(1'b1, 1'b0, 1'b0, 32'h76543210);
    tick(1'b1, 1'b0, 1'b1, 32'h000300FF);
    tick(1'b0, 1'b1, 1'b1, 32'h0);
    chk("duty_rd", rdata, 32'h000300FF);
    go_to(7, 7);
    exp_on = 0;
    got_on = 0;
    for (int i = 0; i < FR; i++) begin
      tick(1'b0, 1'b0, 1'b0, 32'h0);
      if (((m_n - 1) % SD) >= BC && ((m_n - 1) % 16) <= 3) exp_on++;
      if (an !== 8'hFF) got_on++;
    end
    chk("duty_on_count", got_on, exp_on);
`else
    exp_on = 0;
    got_on = 0;
    tick(1'b1, 1'b0, 1'b1, 32'h000F00FF);
    tick(1'b0, 1'b1, 1'b1, 32'h0);
    chk("duty_rd", rdata, 32'h000000FF);
    tick(1'b1, 1'b0, 1'b0, 32'h89ABCDEF);
    go_to(7, 7);
    for (int i = 0; i < FR; i++) begin
      tick(1'b0, 1'b0, 1'b0, 32'h0);
      if (((m_n - 1) % SD) >= BC) exp_on++;
      if (an !== 8'hFF) got_on++;
    end
    chk("full_on_count", got_on, exp_on);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
